// File: rtl/code_loader_if.sv
// Byte-stream and code-memory write bus between a host link, the code loader and code memory.
// The slave side is the loader itself; the master side is the host/memory environment.
interface code_loader_if #(
    parameter int BIT_WIDTH     = 32,
    parameter int INST_COUNT_L2 = 8
);
    logic                     start;
    logic [INST_COUNT_L2:0]   word_count;
    logic                     byte_valid;
    logic [7:0]               byte_data;
    logic                     byte_ready;
    logic                     wr_en;
    logic [INST_COUNT_L2-1:0] wr_addr;
    logic [BIT_WIDTH-1:0]     wr_data;
    logic                     busy;
    logic                     done;
    logic                     cpu_nreset;

    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_nreset
    );

    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_nreset
    );
endinterface

// File: rtl/code_loader.sv
// Assembles little-endian 32-bit words from a byte stream, writes them to code memory
// from address 0 upward, and holds the CPU in reset until the requested word count is loaded.
module code_loader #(
    parameter int BIT_WIDTH     = 32,
    parameter int INST_COUNT    = 256,
    parameter int INST_COUNT_L2 = 8
) (
    input  logic         clk,
    input  logic         nreset,
    code_loader_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [INST_COUNT_L2:0] MAX_COUNT = (INST_COUNT_L2 + 1)'(INST_COUNT);
    localparam logic [INST_COUNT_L2:0] ONE_COUNT = (INST_COUNT_L2 + 1)'(1);

    state_e                   state_q, state_d;
    logic [1:0]               byte_idx_q, byte_idx_d;
    logic [INST_COUNT_L2-1:0] addr_q, addr_d;
    logic [INST_COUNT_L2:0]   count_q, count_d;
    logic [BIT_WIDTH-1:0]     word_q, word_d;
    logic                     wr_en_q, wr_en_d;
    logic [INST_COUNT_L2-1:0] wr_addr_q, wr_addr_d;
    logic [BIT_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [INST_COUNT_L2:0]   clamp_count_s;
    logic                     accept_s;

    // Requests beyond the memory size are clamped so addr can never leave the array.
    assign clamp_count_s  = (bus.word_count > MAX_COUNT) ? MAX_COUNT : bus.word_count;
    assign accept_s       = bus.byte_valid && (state_q == ST_RECV);

    assign bus.byte_ready = (state_q == ST_RECV);
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cpu_nreset = done_q;

    // Next-state and registered-output decode for the load sequencer.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        count_d    = count_q;
        word_d     = word_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    count_d    = clamp_count_s;
                    addr_d     = '0;
                    byte_idx_d = 2'd0;
                    state_d    = (clamp_count_s != '0) ? ST_RECV : ST_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RECV: begin
                if (accept_s) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = bus.byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // The write strobe is registered on the last byte so it lines up with WRITE.
                    if (byte_idx_q == 2'd3) begin
                        state_d   = ST_WRITE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = word_d;
                    end else begin
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_WRITE: begin
                if ({1'b0, addr_q} == (count_q - ONE_COUNT)) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + {{(INST_COUNT_L2-1){1'b0}}, 1'b1};
                    state_d = ST_RECV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RECV) || (state_d == ST_WRITE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= 2'd0;
            addr_q     <= '0;
            count_q    <= '0;
            word_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            word_q     <= word_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: doc/code_loader.md
# code_loader

Writer-side counterpart to the instruction fetcher. It accepts a byte stream from a host link, such as a UART receiver, and assembles little-endian 32-bit instruction words. It writes them sequentially into the code memory write port starting at word address 0, and holds the CPU in reset until the requested number of words has been written. The fetcher then reads the loaded program once the CPU's reset is released.

## Interface

Parameters:
- BIT_WIDTH, 32, width of one instruction word; fixed at 32 for 4-byte assembly.
- INST_COUNT, 256, number of words in code memory.
- INST_COUNT_L2, 8, log2(INST_COUNT); width of the word address.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- nreset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE and DONE.
- word_count  input  INST_COUNT_L2+1  number of words to load; sampled when start is accepted.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  incoming byte.
- byte_ready  output  1  loader accepts a byte this cycle; combinational, equal to (state == RECV).
- wr_en  output  1  code memory write strobe, registered.
- wr_addr  output  INST_COUNT_L2  word address of the write, registered.
- wr_data  output  BIT_WIDTH  word being written, registered; holds its last value.
- busy  output  1  high in RECV and WRITE.
- done  output  1  high in DONE.
- cpu_nreset  output  1  CPU reset, active-low; high only in DONE.

## Operation

- States are IDLE, RECV, WRITE and DONE.
- Reset (nreset=0 at a clock edge) has the following effects:
  - state becomes IDLE.
  - byte_idx, addr, wr_addr, wr_data and the count register all become 0.
  - wr_en, busy, done, byte_ready and cpu_nreset are all 0.
- IDLE:
  - With start=1: the count register is loaded with min(word_count, INST_COUNT), addr=0 and byte_idx=0.
  - If the loaded count is nonzero the next state is RECV; if it is zero the next state is DONE.
- RECV:
  - A byte is accepted on any cycle with byte_valid && byte_ready.
  - The accepted byte is written to word bits [8*byte_idx+7 : 8*byte_idx], and byte_idx increments modulo 4.
  - When the byte with byte_idx==3 is accepted, the next state is WRITE.
  - While byte_valid=0, the loader stays in RECV with no change to its state.
- WRITE:
  - Lasts exactly one cycle; wr_en=1, wr_addr=addr and wr_data=the assembled word. byte_ready=0.
  - If addr == count-1 the next state is DONE; otherwise addr increments and the next state is RECV.
- DONE:
  - done=1 and cpu_nreset=1; remains in DONE indefinitely.
  - start=1 restarts the load exactly as in IDLE. cpu_nreset drops to 0 in the next cycle.
- start is ignored in RECV and WRITE.
- addr never exceeds INST_COUNT-1, because count is clamped to INST_COUNT.
- Bytes presented outside RECV are not accepted. The upstream source must hold byte_data until it sees byte_ready.
- Simultaneous start and byte_valid in IDLE: start is taken; the byte is not accepted because byte_ready=0.

## Timing

- Latency from the 4th byte's accept edge to the write: wr_en is high during the cycle immediately following that edge, so the memory write occurs at the next edge.
- Minimum rate is 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
- A full load of N words with back-to-back bytes takes 1 + 5N cycles from the start cycle to done=1:
  - 1 cycle for IDLE→RECV.
  - DONE is entered at the edge that ends the last WRITE.
- cpu_nreset rises in the same cycle as done, so the CPU's first fetch begins with address 0 already written.
- Reset during RECV or WRITE:
  - At that edge, wr_en goes to 0, the partial word is discarded and the count is lost.
  - Words already written remain in memory.
- wr_en is never high for two consecutive cycles.

## Test plan

- Reset check: hold nreset=0 for 3 cycles. Required: all outputs 0 and byte_ready=0.
- Single-word load: reset, then start with word_count=1, then bytes 0x78, 0x56, 0x34, 0x12 back-to-back. Required:
  - One wr_en pulse with wr_addr=0 and wr_data=0x12345678.
  - done=1 and cpu_nreset=1 exactly 6 cycles after start.
- Three-word load with byte_valid gapped every other cycle. Required:
  - Writes at addresses 0, 1, 2 with the correct little-endian words.
  - wr_en never held for 2 cycles, and done only after the write to address 2.
- word_count=0, and separately word_count=INST_COUNT+5:
  - Zero: DONE one cycle after start, with no wr_en.
  - Overflow: exactly INST_COUNT writes, with the last at wr_addr=INST_COUNT-1.
- Reset after 2 bytes of word 1 in a 2-word load. Required:
  - No further wr_en after the reset, and state returns to IDLE.
  - A subsequent start reloads from wr_addr=0.
- Restart from DONE: pulse start while done=1. Required: cpu_nreset=0 in the next cycle, busy=1, and the new load begins at wr_addr=0.
